ack_responder_fsm: RTL and testbench



---
 rtl/ack_responder_if.sv | 23 ++
 rtl/ack_responder_fsm.sv | 82 ++++++++
 tb/tb_ack_responder_fsm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ack_responder_if.sv
// Handshake bundle between an enable/request/ack initiator and its responder.
interface ack_responder_if #(
  parameter int unsigned DELAY_W = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               active;
  logic               request;
  logic [DELAY_W-1:0] resp_delay;
  logic               ack;
  logic               busy;
  logic [CNT_W-1:0]   xact_count;
  logic               protocol_err;

  modport master (
    output active, request, resp_delay,
    input  ack, busy, xact_count, protocol_err
  );

  modport slave (
    input  active, request, resp_delay,
    output ack, busy, xact_count, protocol_err
  );
endinterface

// File: rtl/ack_responder_fsm.sv
// Responder side of the request/ack handshake: programmable ack delay,
// transaction counting and sticky protocol-error detection.
module ack_responder_fsm #(
  parameter int unsigned DELAY_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  ack_responder_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StDelay, StAck} state_e;

  state_e             r_state, w_state_d;
  logic [DELAY_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0]   r_xact, w_xact_d;
  logic               r_err, w_err_d;
  logic               r_ack, r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_xact  <= '0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_xact  <= w_xact_d;
      r_err   <= w_err_d;
      // Outputs registered from next state so they track the state register exactly.
      r_ack   <= (w_state_d == StAck);
      r_busy  <= (w_state_d != StIdle);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_xact_d  = r_xact;
    w_err_d   = r_err;

    unique case (r_state)
      StIdle: begin
        if (bus.request) begin
          w_cnt_d   = bus.resp_delay;
          w_state_d = (bus.resp_delay == '0) ? StAck : StDelay;
        end
      end
      StDelay: begin
        if (!bus.request) begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else if (r_cnt == DELAY_W'(1)) begin
          w_state_d = StAck;
        end else if (r_cnt != '0) begin
          w_cnt_d = r_cnt - DELAY_W'(1);
        end
      end
      StAck: begin
        if (!bus.request) begin
          w_state_d = StIdle;
          w_xact_d  = r_xact + CNT_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Monitor only: flags the violation without altering the handshake.
    if (bus.request && !bus.active) begin
      w_err_d = 1'b1;
    end
  end

  assign bus.ack          = r_ack;
  assign bus.busy         = r_busy;
  assign bus.xact_count   = r_xact;
  assign bus.protocol_err = r_err;

endmodule

// File: tb/tb_ack_responder_fsm.sv
// Directed self-checking bench for ack_responder_fsm.
module tb_ack_responder_fsm;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   exp_cnt;

  ack_responder_if #(.DELAY_W(4), .CNT_W(8)) u_if ();

  ack_responder_fsm #(.DELAY_W(4), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic a, input logic b,
                            input int x, input logic e);
    check_val({tag, ".ack"},  32'(u_if.ack), 32'(a));
    check_val({tag, ".busy"}, 32'(u_if.busy), 32'(b));
    check_val({tag, ".xact"}, 32'(u_if.xact_count), 32'(x));
    check_val({tag, ".err"},  32'(u_if.protocol_err), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.request = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Full transaction: checks request-to-ack latency equals d, then withdraws.
  task automatic do_xact(input string tag, input int d);
    int lat;
    u_if.request    = 1'b1;
    u_if.resp_delay = 4'(d);
    tick();
    lat = 0;
    while (!u_if.ack && lat < 40) begin
      tick();
      lat++;
    end
    check_val({tag, ".lat"}, 32'(lat), 32'(d));
    u_if.request = 1'b0;
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
    check_val({tag, ".ack_drop"}, 32'(u_if.ack), 32'd0);
    check_val({tag, ".cnt"}, 32'(u_if.xact_count), 32'(exp_cnt));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    rst = 1'b1;
    u_if.active = 1'b1;
    u_if.request = 1'b0;
    u_if.resp_delay = '0;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 0, 1'b0);

    // rst wins over an incoming request
    u_if.request = 1'b1;
    tick();
    check_val("rst_wins.busy", 32'(u_if.busy), 32'd0);
    do_reset();

    // Nominal D=3; resp_delay changed mid-DELAY must be ignored
    u_if.request = 1'b1;
    u_if.resp_delay = 4'd3;
    tick();
    check_outs("nom.n", 1'b0, 1'b1, 0, 1'b0);
    u_if.resp_delay = 4'd9;
    tick();
    check_val("nom.n1.ack", 32'(u_if.ack), 32'd0);
    tick();
    check_val("nom.n2.ack", 32'(u_if.ack), 32'd0);
    tick();
    check_outs("nom.n3", 1'b1, 1'b1, 0, 1'b0);
    tick();
    check_val("nom.n4.ack", 32'(u_if.ack), 32'd1);
    u_if.request = 1'b0;
    tick();
    check_outs("nom.n5", 1'b0, 1'b0, 1, 1'b0);
    exp_cnt = 1;

    // D=0 twice back-to-back
    do_xact("d0a", 0);
    do_xact("d0b", 0);
    check_val("d0.err", 32'(u_if.protocol_err), 32'd0);

    // Reset mid-ACK
    u_if.request = 1'b1;
    u_if.resp_delay = 4'd1;
    tick();
    tick();
    check_val("rstack.pre.ack", 32'(u_if.ack), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check_outs("rstack", 1'b0, 1'b0, 0, 1'b0);
    u_if.request = 1'b0;
    tick();
    do_xact("rstack.d2", 2);

    // active violation during ACK
    u_if.request = 1'b1;
    u_if.resp_delay = 4'd0;
    tick();
    u_if.active = 1'b0;
    tick();
    check_val("actv.err", 32'(u_if.protocol_err), 32'd1);
    check_val("actv.ack", 32'(u_if.ack), 32'd1);
    u_if.active = 1'b1;
    u_if.request = 1'b0;
    tick();
    exp_cnt++;
    check_outs("actv.done", 1'b0, 1'b0, exp_cnt, 1'b1);

    // Early withdrawal, D=5
    do_reset();
    u_if.request = 1'b1;
    u_if.resp_delay = 4'd5;
    tick();
    tick();
    tick();
    check_val("early.mid.ack", 32'(u_if.ack), 32'd0);
    u_if.request = 1'b0;
    tick();
    check_outs("early", 1'b0, 1'b0, 0, 1'b1);
    tick();
    tick();
    check_val("early.sticky", 32'(u_if.protocol_err), 32'd1);
    do_xact("early.next", 4);
    check_val("early.next.err", 32'(u_if.protocol_err), 32'd1);

    // Wrap at max delay
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_xact("wrap", 15);
      if (i == 254) check_val("wrap.255", 32'(u_if.xact_count), 32'd255);
    end
    check_val("wrap.final", 32'(u_if.xact_count), 32'd0);
    check_val("wrap.err", 32'(u_if.protocol_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
